// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the packed sequential multiplier.
// Holds the FSM state encoding and the helpers that size the packed
// operand, the packed product and the pair index counter.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Distance between the hi and lo lanes inside the packed operand.
    // One guard bit above the 2*IN_BITS lo product absorbs its sign.
    function automatic int pack_shift(input int in_bits);
        return 2 * in_bits + 1;
    endfunction

    // Width of the packed product that still holds both lane products.
    function automatic int prod_width(input int in_bits);
        return pack_shift(in_bits) + 2 * in_bits;
    endfunction

    // Width of the pair index; at least one bit even for a single pair.
    function automatic int idx_width(input int num_pairs);
        return (num_pairs > 1) ? $clog2(num_pairs) : 1;
    endfunction

endpackage

// File: rtl/mul_pack_pipe.sv
// mul_pack_pipe: one packed multiply per cycle followed by PIPE_STAGES
// pipeline registers. The pair index and signed mode travel with the data
// so the retire side knows where and how to unpack each product.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   issue_valid/idx/signed   pair entering the multiplier this cycle
//   issue_hi/lo/w            operands of that pair
//   ret_valid/idx/signed     pair leaving the last pipeline stage
//   ret_prod                 packed product of that pair
module mul_pack_pipe
    import mul_pkg::*;
#(
    parameter int IN_BITS     = 8,
    parameter int NUM_PAIRS   = 4,
    parameter int PIPE_STAGES = 2,
    localparam int PW         = prod_width(IN_BITS),
    localparam int IDX_W      = idx_width(NUM_PAIRS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [IDX_W-1:0]   issue_idx,
    input  logic               issue_signed,
    input  logic [IN_BITS-1:0] issue_hi,
    input  logic [IN_BITS-1:0] issue_lo,
    input  logic [IN_BITS-1:0] issue_w,
    output logic               ret_valid,
    output logic [IDX_W-1:0]   ret_idx,
    output logic               ret_signed,
    output logic [PW-1:0]      ret_prod
);

    localparam int SHIFT = pack_shift(IN_BITS);

    logic [PW-1:0] ext_hi;
    logic [PW-1:0] ext_lo;
    logic [PW-1:0] ext_w;
    logic [PW-1:0] packed_a;
    logic [PW-1:0] prod;

    logic             st_valid  [PIPE_STAGES];
    logic [IDX_W-1:0] st_idx    [PIPE_STAGES];
    logic             st_signed [PIPE_STAGES];
    logic [PW-1:0]    st_prod   [PIPE_STAGES];

    // Extend the operands to the product width and form hi*2^SHIFT + lo.
    // Arithmetic modulo 2^PW is exact for the bits the unpacker reads, so
    // a plain unsigned multiply serves both modes.
    always_comb begin
        ext_hi = '0;
        ext_lo = '0;
        ext_w  = '0;
        ext_hi[IN_BITS-1:0] = issue_hi;
        ext_lo[IN_BITS-1:0] = issue_lo;
        ext_w[IN_BITS-1:0]  = issue_w;
        if (issue_signed) begin
            ext_hi[PW-1:IN_BITS] = {(PW-IN_BITS){issue_hi[IN_BITS-1]}};
            ext_lo[PW-1:IN_BITS] = {(PW-IN_BITS){issue_lo[IN_BITS-1]}};
            ext_w[PW-1:IN_BITS]  = {(PW-IN_BITS){issue_w[IN_BITS-1]}};
        end
        packed_a = (ext_hi << SHIFT) + ext_lo;
        prod     = packed_a * ext_w;
    end

    // Stage 0 captures the product; later stages just shift it along.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_valid[i]  <= 1'b0;
                st_idx[i]    <= '0;
                st_signed[i] <= 1'b0;
                st_prod[i]   <= '0;
            end
        end else begin
            st_valid[0]  <= issue_valid;
            st_idx[0]    <= issue_idx;
            st_signed[0] <= issue_signed;
            st_prod[0]   <= prod;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                st_valid[i]  <= st_valid[i-1];
                st_idx[i]    <= st_idx[i-1];
                st_signed[i] <= st_signed[i-1];
                st_prod[i]   <= st_prod[i-1];
            end
        end
    end

    assign ret_valid  = st_valid[PIPE_STAGES-1];
    assign ret_idx    = st_idx[PIPE_STAGES-1];
    assign ret_signed = st_signed[PIPE_STAGES-1];
    assign ret_prod   = st_prod[PIPE_STAGES-1];

endmodule

// File: rtl/mul_packed_seq.sv
// mul_packed_seq: multiplies NUM_PAIRS hi/lo operand pairs by one shared
// multiplicand, one packed multiply per cycle, and presents all products
// together with a valid/ready handshake.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     transaction handshake
//   in_signed             operand mode, captured with the transaction
//   in_hi, in_lo, in_w    packed operand lanes and shared multiplicand
//   out_valid/out_ready   result handshake
//   out_hi, out_lo        packed per-pair products
//   busy                  high whenever a transaction is in flight
module mul_packed_seq
    import mul_pkg::*;
#(
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 32,
    parameter int NUM_PAIRS   = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_signed,
    input  logic [NUM_PAIRS*IN_BITS-1:0]  in_hi,
    input  logic [NUM_PAIRS*IN_BITS-1:0]  in_lo,
    input  logic [IN_BITS-1:0]            in_w,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_PAIRS*OUT_BITS-1:0] out_hi,
    output logic [NUM_PAIRS*OUT_BITS-1:0] out_lo,
    output logic                          busy
);

    if (IN_BITS < 2 || IN_BITS > 8) begin : g_bad_in_bits
        $error("mul_packed_seq: IN_BITS must be 2..8");
    end
    if (OUT_BITS < 2 * IN_BITS) begin : g_bad_out_bits
        $error("mul_packed_seq: OUT_BITS must be >= 2*IN_BITS");
    end
    if (NUM_PAIRS < 1 || NUM_PAIRS > 8) begin : g_bad_num_pairs
        $error("mul_packed_seq: NUM_PAIRS must be 1..8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
        $error("mul_packed_seq: PIPE_STAGES must be 1..4");
    end

    localparam int SHIFT     = pack_shift(IN_BITS);
    localparam int PW        = prod_width(IN_BITS);
    localparam int IDX_W     = idx_width(NUM_PAIRS);
    localparam int PB        = 2 * IN_BITS;
    // The last pair retires PIPE_STAGES cycles after issue; one more cycle
    // fixes the accept-to-valid latency at NUM_PAIRS+PIPE_STAGES+1.
    localparam int DRAIN_LEN = PIPE_STAGES + 1;

    state_t state;
    state_t state_next;

    logic [NUM_PAIRS*IN_BITS-1:0] hold_hi;
    logic [NUM_PAIRS*IN_BITS-1:0] hold_lo;
    logic [IN_BITS-1:0]           hold_w;
    logic                         hold_signed;
    logic [IDX_W-1:0]             issue_idx;
    logic [2:0]                   drain_cnt;
    logic                         issue_valid;

    logic             ret_valid;
    logic [IDX_W-1:0] ret_idx;
    logic             ret_signed;
    logic [PW-1:0]    ret_prod;

    logic [PB-1:0]       lo_field;
    logic [PB-1:0]       hi_field;
    logic [OUT_BITS-1:0] lo_ext;
    logic [OUT_BITS-1:0] hi_ext;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. in_valid only matters in IDLE.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        issue_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = ISSUE;
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_idx == IDX_W'(NUM_PAIRS - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 3'(DRAIN_LEN - 1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding registers and the issue/drain counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_hi     <= '0;
            hold_lo     <= '0;
            hold_w      <= '0;
            hold_signed <= 1'b0;
            issue_idx   <= '0;
            drain_cnt   <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                hold_hi     <= in_hi;
                hold_lo     <= in_lo;
                hold_w      <= in_w;
                hold_signed <= in_signed;
            end
            if (state == ISSUE) issue_idx <= issue_idx + 1'b1;
            else                issue_idx <= '0;
            if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
            else                drain_cnt <= '0;
        end
    end

    mul_pack_pipe #(
        .IN_BITS     (IN_BITS),
        .NUM_PAIRS   (NUM_PAIRS),
        .PIPE_STAGES (PIPE_STAGES)
    ) u_pipe (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_idx    (issue_idx),
        .issue_signed (hold_signed),
        .issue_hi     (hold_hi[issue_idx*IN_BITS +: IN_BITS]),
        .issue_lo     (hold_lo[issue_idx*IN_BITS +: IN_BITS]),
        .issue_w      (hold_w),
        .ret_valid    (ret_valid),
        .ret_idx      (ret_idx),
        .ret_signed   (ret_signed),
        .ret_prod     (ret_prod)
    );

    // Unpack both lanes. A negative lo product borrows one from the hi
    // lane inside the packed sum; its sign bit gives that borrow back.
    always_comb begin
        lo_field = ret_prod[PB-1:0];
        hi_field = ret_prod[SHIFT +: PB]
                 + {{(PB-1){1'b0}}, ret_signed & ret_prod[PB-1]};
        lo_ext   = {OUT_BITS{ret_signed & lo_field[PB-1]}};
        hi_ext   = {OUT_BITS{ret_signed & hi_field[PB-1]}};
        lo_ext[PB-1:0] = lo_field;
        hi_ext[PB-1:0] = hi_field;
    end

    // Result registers keep the previous transaction until overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_hi <= '0;
            out_lo <= '0;
        end else if (ret_valid) begin
            out_hi[ret_idx*OUT_BITS +: OUT_BITS] <= hi_ext;
            out_lo[ret_idx*OUT_BITS +: OUT_BITS] <= lo_ext;
        end
    end

endmodule

// File: tb/tb_mul_packed_seq.sv
module tb_mul_packed_seq;

    localparam int IN_BITS     = 8;
    localparam int OUT_BITS    = 32;
    localparam int NUM_PAIRS   = 4;
    localparam int PIPE_STAGES = 2;
    localparam int LATENCY     = NUM_PAIRS + PIPE_STAGES + 1;

    logic                          clk;
    logic                          rst;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_signed;
    logic [NUM_PAIRS*IN_BITS-1:0]  in_hi;
    logic [NUM_PAIRS*IN_BITS-1:0]  in_lo;
    logic [IN_BITS-1:0]            in_w;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_PAIRS*OUT_BITS-1:0] out_hi;
    logic [NUM_PAIRS*OUT_BITS-1:0] out_lo;
    logic                          busy;

    int vectors     = 0;
    int miscompares = 0;

    mul_packed_seq #(
        .IN_BITS     (IN_BITS),
        .OUT_BITS    (OUT_BITS),
        .NUM_PAIRS   (NUM_PAIRS),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_hi     (in_hi),
        .in_lo     (in_lo),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference product computed with ordinary integer arithmetic.
    function automatic logic [31:0] golden(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return 32'(ia * ib);
    endfunction

    // Offer one transaction, then wait (bounded) for out_valid with
    // out_ready low. Returns at the negedge where out_valid is first seen.
    task automatic start_txn(input logic [31:0] hi, input logic [31:0] lo,
                             input logic [7:0] w, input logic s,
                             output int lat);
        @(negedge clk);
        in_hi     = hi;
        in_lo     = lo;
        in_w      = w;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_hi     = '0;
        in_lo     = '0;
        in_w      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        vectors++;
        if (out_hi !== '0 || out_lo !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: out_hi=%h out_lo=%h, want 0", out_hi, out_lo);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL after_reset: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_signed_basic();
        int lat;
        start_txn({4{8'd3}}, {4{8'hFB}}, 8'd7, 1'b1, lat);
        vectors++;
        if (lat !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL signed_latency: got %0d cycles, want %0d", lat, LATENCY);
        end
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_flags: in_ready=%b busy=%b, want 0 1", in_ready, busy);
        end
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'd21 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'hFFFFFFDD) begin
                miscompares++;
                $display("[TB] FAIL signed_basic lane %0d: hi=%h lo=%h, want 00000015 ffffffdd",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
    endtask

    task automatic test_signed_corner();
        int lat;
        start_txn({4{8'h80}}, {4{8'h80}}, 8'h80, 1'b1, lat);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'd16384 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'd16384) begin
                miscompares++;
                $display("[TB] FAIL min_squared lane %0d: hi=%h lo=%h, want 00004000 00004000",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
        start_txn({4{8'h7F}}, {4{8'h80}}, 8'h80, 1'b1, lat);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'hFFFFC080 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'd16384) begin
                miscompares++;
                $display("[TB] FAIL max_by_min lane %0d: hi=%h lo=%h, want ffffc080 00004000",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
    endtask

    task automatic test_unsigned();
        int lat;
        start_txn({4{8'hFF}}, {4{8'hFF}}, 8'hFF, 1'b0, lat);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'd65025 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'd65025) begin
                miscompares++;
                $display("[TB] FAIL unsigned_max lane %0d: hi=%h lo=%h, want 0000fe01 0000fe01",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
    endtask

    task automatic test_mixed_lanes();
        int lat;
        logic [31:0] exp_hi [NUM_PAIRS];
        logic [31:0] exp_lo [NUM_PAIRS];
        // w = -3; hi = 1, -2, 50, -100; lo = 0, 127, -1, 10
        exp_hi = '{32'hFFFFFFFD, 32'h00000006, 32'hFFFFFF6A, 32'h0000012C};
        exp_lo = '{32'h00000000, 32'hFFFFFE83, 32'h00000003, 32'hFFFFFFE2};
        start_txn({8'h9C, 8'h32, 8'hFE, 8'h01}, {8'h0A, 8'hFF, 8'h7F, 8'h00},
                  8'hFD, 1'b1, lat);
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== exp_hi[k] ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== exp_lo[k]) begin
                miscompares++;
                $display("[TB] FAIL mixed lane %0d: hi=%h lo=%h, want %h %h",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS],
                         exp_hi[k], exp_lo[k]);
            end
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        start_txn({4{8'd2}}, {4{8'd3}}, 8'd10, 1'b0, lat);
        // Offer a second transaction while the first is stalled in DONE.
        in_hi     = {4{8'h80}};
        in_lo     = {4{8'h80}};
        in_w      = 8'h80;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_hi[31:0] !== 32'd20 || out_lo[31:0] !== 32'd30) begin
                miscompares++;
                $display("[TB] FAIL stall cycle %0d: out_valid=%b in_ready=%b hi0=%h lo0=%h, want 1 0 14 1e",
                         c, out_valid, in_ready, out_hi[31:0], out_lo[31:0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            out_hi[31:0] !== 32'd20) begin
            miscompares++;
            $display("[TB] FAIL post_handshake: in_ready=%b busy=%b out_valid=%b hi0=%h, want 1 0 0 14",
                     in_ready, busy, out_valid, out_hi[31:0]);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL second_latency: got %0d cycles, want %0d", lat, LATENCY);
        end
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'd16384 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'd16384) begin
                miscompares++;
                $display("[TB] FAIL second_txn lane %0d: hi=%h lo=%h, want 00004000 00004000",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
    endtask

    task automatic test_reset_in_drain();
        int lat;
        @(negedge clk);
        in_hi     = {4{8'd3}};
        in_lo     = {4{8'hFB}};
        in_w      = 8'd7;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL in_drain: busy=%b out_valid=%b, want 1 0", busy, out_valid);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_hi !== '0 || out_lo !== '0) begin
            miscompares++;
            $display("[TB] FAIL drain_reset: out_valid=%b busy=%b out_hi=%h out_lo=%h, want all 0",
                     out_valid, busy, out_hi, out_lo);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL aborted cycle %0d: out_valid=%b busy=%b, want 0 0",
                         c, out_valid, busy);
            end
        end
        start_txn({4{8'd2}}, {4{8'hFF}}, 8'hFC, 1'b1, lat);
        vectors++;
        if (lat !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL after_abort_latency: got %0d cycles, want %0d", lat, LATENCY);
        end
        for (int k = 0; k < NUM_PAIRS; k++) begin
            vectors++;
            if (out_hi[k*OUT_BITS +: OUT_BITS] !== 32'hFFFFFFF8 ||
                out_lo[k*OUT_BITS +: OUT_BITS] !== 32'd4) begin
                miscompares++;
                $display("[TB] FAIL after_abort lane %0d: hi=%h lo=%h, want fffffff8 00000004",
                         k, out_hi[k*OUT_BITS +: OUT_BITS], out_lo[k*OUT_BITS +: OUT_BITS]);
            end
        end
        handshake();
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  w;
        logic        s;
        logic [31:0] eh;
        logic [31:0] el;
        for (int t = 0; t < 200; t++) begin
            hi = $urandom();
            lo = $urandom();
            w  = 8'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            start_txn(hi, lo, w, s, lat);
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("[TB] FAIL rand %0d latency: got %0d cycles, want %0d", t, lat, LATENCY);
            end
            for (int k = 0; k < NUM_PAIRS; k++) begin
                eh = golden(hi[k*8 +: 8], w, s);
                el = golden(lo[k*8 +: 8], w, s);
                vectors++;
                if (out_hi[k*OUT_BITS +: OUT_BITS] !== eh ||
                    out_lo[k*OUT_BITS +: OUT_BITS] !== el) begin
                    miscompares++;
                    $display("[TB] FAIL rand %0d lane %0d: hi=%h lo=%h, want %h %h",
                             t, k, out_hi[k*OUT_BITS +: OUT_BITS],
                             out_lo[k*OUT_BITS +: OUT_BITS], eh, el);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_signed_corner();
        test_unsigned();
        test_mixed_lanes();
        test_backpressure();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
